// File: rtl/status_monitor.sv
// status_monitor
// Board-status monitor for the LED panel driver. Turns the per-frame led_blank
// rising edge into a wrapping frame counter whose MSB is a heartbeat LED.
// Runs a frame watchdog that flags a stalled driver. Synchronises the
// asynchronous, active-low led_xerr and optionally holds a sticky copy of it.
// Every status_* output comes from a register or from an OR of registers, so
// the LEDs never glitch.

module status_monitor #(
    parameter int CNT_WIDTH   = 10,
    parameter int WDOG_CYCLES = 1_000_000,
    parameter int SYNC_STAGES = 2,
    parameter int RED_STICKY  = 1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 led_blank,
    input  logic                 led_xerr,
    input  logic                 err_clear,
    output logic [CNT_WIDTH-1:0] frame_count,
    output logic                 err_sticky,
    output logic                 status_yellow,
    output logic                 status_orange,
    output logic                 status_red
);

    // The watchdog counter only needs to reach WDOG_CYCLES, where it saturates.
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
    localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(WDOG_CYCLES);
    localparam logic STICKY_EN = (RED_STICKY != 0);

    logic                   blank_prev;
    logic                   blank_rise;
    logic [WDOG_W-1:0]      wdog_cnt;
    logic [WDOG_W-1:0]      wdog_next;
    logic                   stall_q;
    logic [SYNC_STAGES-1:0] sync_chain;
    logic                   err_live;

    // Detect the blank rising edge. blank_prev resets high, so a blank that is
    // already high when reset releases does not count as a frame.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            blank_prev <= 1'b1;
        end else begin
            blank_prev <= led_blank;
        end
    end

    assign blank_rise = led_blank & ~blank_prev;

    // Count frames; the counter wraps from all-ones back to zero.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            frame_count <= '0;
        end else if (blank_rise) begin
            frame_count <= frame_count + CNT_WIDTH'(1);
        end
    end

    assign status_yellow = frame_count[CNT_WIDTH-1];

    // Work out the next watchdog count: restart on a frame, otherwise count up
    // and hold at the limit so a long stall never wraps back to "healthy".
    always_comb begin
        wdog_next = wdog_cnt;
        if (blank_rise) begin
            wdog_next = '0;
        end else if (wdog_cnt != WDOG_LIMIT) begin
            wdog_next = wdog_cnt + WDOG_W'(1);
        end
    end

    // Register the count and the stall flag. The flag is compared on the next
    // value, so it always equals (wdog_cnt == WDOG_CYCLES) but comes straight
    // from a flop.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wdog_cnt <= '0;
            stall_q  <= 1'b0;
        end else begin
            wdog_cnt <= wdog_next;
            stall_q  <= (wdog_next == WDOG_LIMIT);
        end
    end

    assign status_orange = stall_q;

    // Synchronise led_xerr. The chain resets to 1, which is the inactive level.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_chain <= '1;
        end else begin
            sync_chain <= {sync_chain[SYNC_STAGES-2:0], led_xerr};
        end
    end

    assign err_live = ~sync_chain[SYNC_STAGES-1];

    // Latch any error seen since the last clear. A new error in the same cycle
    // as a clear wins, so an error that is still present is never lost.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err_sticky <= 1'b0;
        end else if (err_live) begin
            err_sticky <= 1'b1;
        end else if (err_clear) begin
            err_sticky <= 1'b0;
        end
    end

    assign status_red = err_live | (STICKY_EN & err_sticky);

endmodule

// File: tb/tb_status_monitor.sv
// tb_status_monitor
// Directed bench for status_monitor. It runs two instances side by side on the
// same inputs: one with the sticky red indicator and one without. A vector
// table covers the frame counter and the error path. Hand-written sequences
// cover the watchdog, set-wins-over-clear and asynchronous reset in mid-operation.

module tb_status_monitor;

    localparam int CW = 4;
    localparam int WD = 16;
    localparam int SS = 2;

    logic          clock     = 1'b0;
    logic          reset_n   = 1'b0;
    logic          led_blank = 1'b1;
    logic          led_xerr  = 1'b1;
    logic          err_clear = 1'b0;
    logic [CW-1:0] fc_a, fc_b;
    logic          st_a, st_b, y_a, y_b, o_a, o_b, r_a, r_b;

    int checks = 0;
    int passes = 0;

    typedef struct {
        logic          blank;
        logic          xerr;
        logic          clr;
        logic [CW-1:0] fc;
        logic          yellow;
        logic          orange;
        logic          red_a;
        logic          red_b;
        logic          sticky;
    } vec_t;

    vec_t vecs[$];

    // 100 MHz-style free-running clock
    always #5 clock = ~clock;

    status_monitor #(
        .CNT_WIDTH(CW), .WDOG_CYCLES(WD), .SYNC_STAGES(SS), .RED_STICKY(1)
    ) dut_a (
        .clock(clock), .reset_n(reset_n), .led_blank(led_blank),
        .led_xerr(led_xerr), .err_clear(err_clear), .frame_count(fc_a),
        .err_sticky(st_a), .status_yellow(y_a), .status_orange(o_a),
        .status_red(r_a)
    );

    status_monitor #(
        .CNT_WIDTH(CW), .WDOG_CYCLES(WD), .SYNC_STAGES(SS), .RED_STICKY(0)
    ) dut_b (
        .clock(clock), .reset_n(reset_n), .led_blank(led_blank),
        .led_xerr(led_xerr), .err_clear(err_clear), .frame_count(fc_b),
        .err_sticky(st_b), .status_yellow(y_b), .status_orange(o_b),
        .status_red(r_b)
    );

    // Compare one value and keep the running counts
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Drive one set of inputs, then sample just after the next rising edge
    task automatic applyStimulus(input logic b, input logic x, input logic c);
        led_blank = b;
        led_xerr  = x;
        err_clear = c;
        @(posedge clock);
        #1;
    endtask

    // Check every output of both instances against one expectation
    task automatic checkAll(input string tag, input logic [CW-1:0] fc,
                            input logic y, input logic o, input logic ra,
                            input logic rb, input logic st);
        checkOutput({tag, " fc_a"},   32'(fc_a), 32'(fc));
        checkOutput({tag, " fc_b"},   32'(fc_b), 32'(fc));
        checkOutput({tag, " yel_a"},  32'(y_a),  32'(y));
        checkOutput({tag, " yel_b"},  32'(y_b),  32'(y));
        checkOutput({tag, " org_a"},  32'(o_a),  32'(o));
        checkOutput({tag, " org_b"},  32'(o_b),  32'(o));
        checkOutput({tag, " red_a"},  32'(r_a),  32'(ra));
        checkOutput({tag, " red_b"},  32'(r_b),  32'(rb));
        checkOutput({tag, " stk_a"},  32'(st_a), 32'(st));
        checkOutput({tag, " stk_b"},  32'(st_b), 32'(st));
    endtask

    // Hold reset for two clocks with blank high, then release away from the edge
    task automatic doReset();
        reset_n   = 1'b0;
        led_blank = 1'b1;
        led_xerr  = 1'b1;
        err_clear = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    function automatic void addVec(input logic b, input logic x, input logic c,
                                   input logic [CW-1:0] fc, input logic y,
                                   input logic ra, input logic rb, input logic st);
        vec_t v;
        v.blank = b; v.xerr = x; v.clr = c; v.fc = fc; v.yellow = y;
        v.orange = 1'b0; v.red_a = ra; v.red_b = rb; v.sticky = st;
        vecs.push_back(v);
    endfunction

    // Absolute time limit so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1, "[TB] timeout");
    end

    // Main test sequence
    initial begin
        logic [CW-1:0] cnt;

        // Blank held high through reset and for three clocks after: no frame
        for (int i = 0; i < 3; i++) addVec(1, 1, 0, 0, 0, 0, 0, 0);
        // Sixteen blank pulses: heartbeat goes high at 8 and the count wraps at 16
        for (int p = 1; p <= 16; p++) begin
            cnt = CW'(p - 1);
            addVec(0, 1, 0, cnt, (((p - 1) % 16) >= 8), 0, 0, 0);
            cnt = CW'(p);
            addVec(1, 1, 0, cnt, ((p % 16) >= 8), 0, 0, 0);
        end
        // One-clock xerr pulse, two-stage sync, then clear
        addVec(1, 0, 0, 0, 0, 0, 0, 0);
        addVec(1, 1, 0, 0, 0, 1, 1, 0);
        addVec(1, 1, 0, 0, 0, 1, 0, 1);
        addVec(1, 1, 0, 0, 0, 1, 0, 1);
        addVec(1, 1, 1, 0, 0, 0, 0, 0);
        addVec(1, 1, 0, 0, 0, 0, 0, 0);

        doReset();
        checkAll("reset", 0, 0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].blank, vecs[i].xerr, vecs[i].clr);
            checkAll($sformatf("vec%0d", i), vecs[i].fc, vecs[i].yellow,
                     vecs[i].orange, vecs[i].red_a, vecs[i].red_b, vecs[i].sticky);
        end

        // Watchdog: stall appears exactly WD clocks after reset and saturates
        doReset();
        repeat (WD - 1) applyStimulus(1, 1, 0);
        checkOutput("wdog_15 org_a", 32'(o_a), 32'd0);
        checkOutput("wdog_15 org_b", 32'(o_b), 32'd0);
        applyStimulus(1, 1, 0);
        checkOutput("wdog_16 org_a", 32'(o_a), 32'd1);
        checkOutput("wdog_16 org_b", 32'(o_b), 32'd1);
        repeat (30) applyStimulus(1, 1, 0);
        checkOutput("wdog_sat org_a", 32'(o_a), 32'd1);
        applyStimulus(0, 1, 0);
        checkOutput("wdog_low org_a", 32'(o_a), 32'd1);
        applyStimulus(1, 1, 0);
        checkOutput("wdog_rise org_a", 32'(o_a), 32'd0);
        checkOutput("wdog_rise fc_a", 32'(fc_a), 32'd1);
        repeat (WD - 1) applyStimulus(1, 1, 0);
        checkOutput("wdog_re15 org_a", 32'(o_a), 32'd0);
        applyStimulus(1, 1, 0);
        checkOutput("wdog_re16 org_a", 32'(o_a), 32'd1);

        // Set wins over clear, then asynchronous reset in mid-stall
        doReset();
        for (int p = 0; p < 9; p++) begin
            applyStimulus(0, 1, 0);
            applyStimulus(1, 1, 0);
        end
        checkAll("nine", 9, 1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0);
        applyStimulus(1, 0, 0);
        checkAll("xlow2", 9, 1, 0, 1, 1, 0);
        applyStimulus(1, 0, 0);
        checkAll("xlow3", 9, 1, 0, 1, 1, 1);
        applyStimulus(1, 0, 1);
        checkAll("setwins", 9, 1, 0, 1, 1, 1);
        repeat (20) applyStimulus(1, 0, 0);
        checkAll("stall", 9, 1, 1, 1, 1, 1);
        #2;
        reset_n = 1'b0;
        #1;
        checkAll("midreset", 0, 0, 0, 0, 0, 0);
        led_xerr = 1'b1;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        repeat (3) applyStimulus(1, 1, 0);
        checkAll("postreset", 0, 0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
